// File: rtl/inst_fetch_queue_if.sv
// Bundles the IFU-side fetch signals and the decode-side valid/ready head
// outputs of the instruction fetch queue.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

interface inst_fetch_queue_if #(
    parameter int DEPTH           = 8,
    parameter int FETCH_WIDTH     = `FETCH_WIDTH,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                       flush;
    logic                       new_valid_inst;
    logic [31:0]                Instruction_Code [FETCH_WIDTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [INST_ADDR_WIDTH-1:0] pc_plus_4;
    logic                       stall;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [31:0]                dec_inst [FETCH_WIDTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] dec_pc;
    logic [INST_ADDR_WIDTH-1:0] dec_pc_plus_4;
    logic [CNT_W-1:0]           count;

    modport master (
        output flush, new_valid_inst, Instruction_Code, pc, pc_plus_4, dec_ready,
        input  stall, dec_valid, dec_inst, dec_pc, dec_pc_plus_4, count
    );

    modport slave (
        input  flush, new_valid_inst, Instruction_Code, pc, pc_plus_4, dec_ready,
        output stall, dec_valid, dec_inst, dec_pc, dec_pc_plus_4, count
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular buffer decoupling the IFU from decode: in-order fetch groups,
// full-based stall to the IFU, single-cycle flush.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 2
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module inst_fetch_queue #(
    parameter int DEPTH           = 8,
    parameter int FETCH_WIDTH     = `FETCH_WIDTH,
    parameter int INST_ADDR_WIDTH = `INST_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    inst_fetch_queue_if.slave     q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [31:0]                inst_mem_q [DEPTH-1:0][FETCH_WIDTH-1:0];
    logic [31:0]                inst_mem_d [DEPTH-1:0][FETCH_WIDTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] pc_mem_q  [DEPTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] pc_mem_d  [DEPTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] pc4_mem_q [DEPTH-1:0];
    logic [INST_ADDR_WIDTH-1:0] pc4_mem_d [DEPTH-1:0];

    logic full, empty, enq, deq, dec_valid;

    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        dec_valid = ~empty & ~q.flush;
        enq       = q.new_valid_inst & ~full & ~q.flush;
        deq       = dec_valid & q.dec_ready;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (q.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + PTR_W'(1);
            if (deq) rptr_d = rptr_q + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        pc4_mem_d  = pc4_mem_q;
        if (enq) begin
            inst_mem_d[wptr_q] = q.Instruction_Code;
            pc_mem_d[wptr_q]   = q.pc;
            pc4_mem_d[wptr_q]  = q.pc_plus_4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
        pc4_mem_q  <= pc4_mem_d;
    end

    always_comb begin
        q.stall         = full;
        q.dec_valid     = dec_valid;
        q.dec_inst      = inst_mem_q[rptr_q];
        q.dec_pc        = pc_mem_q[rptr_q];
        q.dec_pc_plus_4 = pc4_mem_q[rptr_q];
        q.count         = count_q;
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: reset, fill/stall, wrap, flush,
// simultaneous enq/deq and asynchronous reset scenarios.
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    inst_fetch_queue_if #(.DEPTH(8), .FETCH_WIDTH(2), .INST_ADDR_WIDTH(32)) ifc ();

    inst_fetch_queue #(.DEPTH(8), .FETCH_WIDTH(2), .INST_ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pcv, input logic [31:0] i0, input logic [31:0] i1);
        ifc.new_valid_inst      = v;
        ifc.pc                  = pcv;
        ifc.pc_plus_4           = pcv + 32'd4;
        ifc.Instruction_Code[0] = i0;
        ifc.Instruction_Code[1] = i1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #20;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ifc.count); end
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifc.dec_valid); end
        checks++; if (ifc.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", ifc.stall); end
        reset = 1'b0;
        tick();
        drive(1'b1, 32'h0, 32'h00500093, 32'h0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 32'h0);
        checks++; if (ifc.dec_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", ifc.dec_valid); end
        checks++; if (ifc.dec_pc !== 32'h0) begin errors++; $display("FAIL single_pc got %0h exp 0", ifc.dec_pc); end
        checks++; if (ifc.dec_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL single_pc4 got %0h exp 4", ifc.dec_pc_plus_4); end
        checks++; if (ifc.dec_inst[0] !== 32'h00500093) begin errors++; $display("FAIL single_inst got %0h exp 00500093", ifc.dec_inst[0]); end
        checks++; if (ifc.count !== 4'd1) begin errors++; $display("FAIL single_count got %0d exp 1", ifc.count); end
        ifc.dec_ready = 1'b1;
        tick();
        ifc.dec_ready = 1'b0;
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %b exp 0", ifc.dec_valid); end
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL single_drain_count got %0d exp 0", ifc.count); end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i), 32'(i), ~32'(i));
            checks++; if (ifc.stall !== 1'b0) begin errors++; $display("FAIL fill_stall_early i=%0d got %b exp 0", i, ifc.stall); end
            tick();
        end
        checks++; if (ifc.stall !== 1'b1) begin errors++; $display("FAIL fill_stall got %b exp 1", ifc.stall); end
        checks++; if (ifc.count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", ifc.count); end
        drive(1'b1, 32'd32, 32'h99, 32'h98);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifc.count !== 4'd8) begin errors++; $display("FAIL held_count c=%0d got %0d exp 8", i, ifc.count); end
        end
        checks++; if (ifc.dec_pc !== 32'd0) begin errors++; $display("FAIL full_head_pc got %0d exp 0", ifc.dec_pc); end
        ifc.dec_ready = 1'b1;
        tick();
        ifc.dec_ready = 1'b0;
        checks++; if (ifc.count !== 4'd7) begin errors++; $display("FAIL full_deq_count got %0d exp 7", ifc.count); end
        checks++; if (ifc.stall !== 1'b0) begin errors++; $display("FAIL full_deq_stall got %b exp 0", ifc.stall); end
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.count !== 4'd8) begin errors++; $display("FAIL refill_count got %0d exp 8", ifc.count); end
        checks++; if (ifc.stall !== 1'b1) begin errors++; $display("FAIL refill_stall got %b exp 1", ifc.stall); end
        ifc.dec_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if (ifc.dec_pc !== 32'(4 * k)) begin errors++; $display("FAIL drain_pc k=%0d got %0d exp %0d", k, ifc.dec_pc, 4 * k); end
            if (k < 8) begin
                checks++; if (ifc.dec_inst[1] !== ~32'(k)) begin errors++; $display("FAIL drain_inst1 k=%0d got %0h exp %0h", k, ifc.dec_inst[1], ~32'(k)); end
            end else begin
                checks++; if (ifc.dec_inst[1] !== 32'h98) begin errors++; $display("FAIL drain_inst1 k=8 got %0h exp 98", ifc.dec_inst[1]); end
            end
            tick();
        end
        ifc.dec_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", ifc.count); end
    endtask

    task automatic test_wrap();
        ifc.dec_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(4 * i), 32'(100 + i), 32'(200 + i));
            if (i > 0) begin
                checks++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== 32'(4 * (i - 1))) begin
                    errors++; $display("FAIL wrap_head i=%0d got v=%b pc=%0d exp v=1 pc=%0d", i, ifc.dec_valid, ifc.dec_pc, 4 * (i - 1));
                end
            end
            tick();
            checks++; if (ifc.count !== 4'd1) begin errors++; $display("FAIL wrap_count i=%0d got %0d exp 1", i, ifc.count); end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.dec_pc !== 32'd76 || ifc.dec_inst[0] !== 32'd119) begin
            errors++; $display("FAIL wrap_last got pc=%0d inst=%0d exp pc=76 inst=119", ifc.dec_pc, ifc.dec_inst[0]);
        end
        tick();
        ifc.dec_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL wrap_end_count got %0d exp 0", ifc.count); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'(4 * i), 32'(i), 32'(i));
            tick();
        end
        checks++; if (ifc.count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d exp 5", ifc.count); end
        drive(1'b1, 32'h14, 32'h14, 32'h14);
        ifc.dec_ready = 1'b1;
        ifc.flush     = 1'b1;
        #1;
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle_valid got %b exp 0", ifc.dec_valid); end
        tick();
        ifc.flush     = 1'b0;
        ifc.dec_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ifc.count); end
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", ifc.dec_valid); end
        tick();
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid got %b exp 0", ifc.dec_valid); end
        drive(1'b1, 32'h10, 32'h10, 32'h11);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== 32'h10 || ifc.count !== 4'd1) begin
            errors++; $display("FAIL flush_reenq got v=%b pc=%0h cnt=%0d exp v=1 pc=10 cnt=1", ifc.dec_valid, ifc.dec_pc, ifc.count);
        end
        ifc.dec_ready = 1'b1;
        tick();
        ifc.dec_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 32'(i), 32'(i));
            tick();
        end
        ifc.dec_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h10C + 32'(4 * k), 32'(k), 32'(k));
            checks++; if (ifc.dec_pc !== 32'h100 + 32'(4 * k)) begin errors++; $display("FAIL b2b_head k=%0d got %0h exp %0h", k, ifc.dec_pc, 32'h100 + 32'(4 * k)); end
            tick();
            checks++; if (ifc.count !== 4'd3 || ifc.stall !== 1'b0) begin
                errors++; $display("FAIL b2b_count k=%0d got cnt=%0d stall=%b exp cnt=3 stall=0", k, ifc.count, ifc.stall);
            end
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            checks++; if (ifc.dec_pc !== 32'h110 + 32'(4 * k)) begin errors++; $display("FAIL b2b_drain k=%0d got %0h exp %0h", k, ifc.dec_pc, 32'h110 + 32'(4 * k)); end
            tick();
        end
        ifc.dec_ready = 1'b0;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL b2b_end_count got %0d exp 0", ifc.count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'(i), 32'(i));
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.count !== 4'd6) begin errors++; $display("FAIL areset_pre_count got %0d exp 6", ifc.count); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (ifc.count !== 4'd0) begin errors++; $display("FAIL areset_count got %0d exp 0", ifc.count); end
        checks++; if (ifc.dec_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", ifc.dec_valid); end
        checks++; if (ifc.stall !== 1'b0) begin errors++; $display("FAIL areset_stall got %b exp 0", ifc.stall); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h200, 32'hABCD, 32'h1234);
        tick();
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        checks++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== 32'h200 || ifc.count !== 4'd1) begin
            errors++; $display("FAIL areset_reenq got v=%b pc=%0h cnt=%0d exp v=1 pc=200 cnt=1", ifc.dec_valid, ifc.dec_pc, ifc.count);
        end
        checks++; if (ifc.dec_inst[1] !== 32'h1234) begin errors++; $display("FAIL areset_inst got %0h exp 1234", ifc.dec_inst[1]); end
    endtask

    initial begin
        reset         = 1'b1;
        ifc.flush     = 1'b0;
        ifc.dec_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        test_reset();
        test_fill_full();
        test_wrap();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
